// File: rtl/twos_comp_serial_pkg.sv
// Shared mode and lane-state encodings for the bit-serial two's-complement unit.
package twos_comp_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_NEG  = 2'b01,
        MODE_ONES = 2'b10
    } mode_t;

    typedef enum logic {
        ST_COPY   = 1'b0,
        ST_INVERT = 1'b1
    } lane_state_t;

    // Code 11 is reserved and behaves as PASS.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   decode_mode = MODE_NEG;
            2'b10:   decode_mode = MODE_ONES;
            default: decode_mode = MODE_PASS;
        endcase
    endfunction

endpackage

// File: rtl/twos_comp_serial_if.sv
// Serial bit stream bundle between the deserialiser and the two's-complement unit.
interface twos_comp_serial_if #(
    parameter int CH = 1
);
    logic          in_valid;
    logic [CH-1:0] incode;
    logic [1:0]    mode;
    logic          abort;
    logic [CH-1:0] outcode;
    logic          out_valid;
    logic          out_last;
    logic [CH-1:0] ovf;

    modport master (
        output in_valid, incode, mode, abort,
        input  outcode, out_valid, out_last, ovf
    );

    modport slave (
        input  in_valid, incode, mode, abort,
        output outcode, out_valid, out_last, ovf
    );
endinterface

// File: rtl/twos_comp_serial_lane.sv
// One lane: copy-until-first-one-then-invert state, registered output bit and overflow flag.
module twos_comp_lane
    import twos_comp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  abort,
    input  logic  accept,
    input  logic  first,
    input  logic  last,
    input  mode_t mode,
    input  logic  in_bit,
    output logic  out_bit,
    output logic  ovf
);

    lane_state_t state_reg;
    lane_state_t state_eff;

    // The word boundary re-arms the lane before its first bit is evaluated.
    assign state_eff = first ? ST_COPY : state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_COPY;
            out_bit   <= 1'b0;
            ovf       <= 1'b0;
        end else if (abort) begin
            state_reg <= ST_COPY;
            ovf       <= 1'b0;
        end else if (accept) begin
            case (mode)
                MODE_NEG: begin
                    if (state_eff == ST_INVERT) begin
                        out_bit   <= ~in_bit;
                        state_reg <= ST_INVERT;
                        ovf       <= 1'b0;
                    end else begin
                        out_bit   <= in_bit;
                        state_reg <= in_bit ? ST_INVERT : ST_COPY;
                        // Still copying at the MSB with a one: input was 100..0.
                        ovf       <= last & in_bit;
                    end
                end
                MODE_ONES: begin
                    out_bit   <= ~in_bit;
                    state_reg <= ST_COPY;
                    ovf       <= 1'b0;
                end
                default: begin
                    out_bit   <= in_bit;
                    state_reg <= ST_COPY;
                    ovf       <= 1'b0;
                end
            endcase
        end else begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/twos_comp_serial.sv
// Multi-lane bit-serial two's-complement unit with word framing, mode capture and abort.
module twos_comp_serial
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CH    = 1
) (
    input  logic clk,
    input  logic rst,
    twos_comp_serial_if.slave bus
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0] idx_reg;
    mode_t         mode_q;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic          first;
    logic          last;
    logic          accept;
    mode_t         mode_eff;
    logic [CH-1:0] outcode_w;
    logic [CH-1:0] ovf_w;

    assign first    = (idx_reg == '0);
    assign last     = (idx_reg == IW'(WIDTH - 1));
    assign accept   = bus.in_valid & ~bus.abort;
    // The live mode only matters on the first bit; the rest of the word follows mode_q.
    assign mode_eff = first ? decode_mode(bus.mode) : mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg       <= '0;
            mode_q        <= MODE_PASS;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (bus.abort) begin
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else if (bus.in_valid) begin
            idx_reg       <= last ? '0 : idx_reg + 1'b1;
            out_valid_reg <= 1'b1;
            out_last_reg  <= last;
            if (first) begin
                mode_q <= mode_eff;
            end
        end else begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        twos_comp_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .abort   (bus.abort),
            .accept  (accept),
            .first   (first),
            .last    (last),
            .mode    (mode_eff),
            .in_bit  (bus.incode[gi]),
            .out_bit (outcode_w[gi]),
            .ovf     (ovf_w[gi])
        );
    end

    assign bus.outcode   = outcode_w;
    assign bus.ovf       = ovf_w;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Directed bench: WIDTH=4/CH=2 instance for framing, modes, gaps, abort and reset; WIDTH=1/CH=1 for single-bit words.
module tb_twos_comp_serial;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    twos_comp_serial_if #(.CH(2)) ifa ();
    twos_comp_serial_if #(.CH(1)) ifb ();

    twos_comp_serial #(.WIDTH(4), .CH(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    twos_comp_serial #(.WIDTH(1), .CH(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [1:0] bits, input logic [1:0] m, input logic ab);
        ifa.in_valid = v;
        ifa.incode   = bits;
        ifa.mode     = m;
        ifa.abort    = ab;
    endtask

    // Send one 4-bit word on both lanes LSB first; m0 is driven on bit 0, m_rest on later bits.
    task automatic send_word(input string tag, input logic [1:0] m0, input logic [1:0] m_rest,
                             input logic [3:0] w0, input logic [3:0] w1,
                             input logic [3:0] e0, input logic [3:0] e1,
                             input logic [1:0] eovf, input int gap);
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, {w1[i], w0[i]}, (i == 0) ? m0 : m_rest, 1'b0);
            tick();
            $display("%s bit%0d out=%b valid=%b last=%b ovf=%b", tag, i,
                     ifa.outcode, ifa.out_valid, ifa.out_last, ifa.ovf);
            check({tag, "_out"},   {6'd0, ifa.outcode}, {6'd0, e1[i], e0[i]});
            check({tag, "_valid"}, {7'd0, ifa.out_valid}, 8'd1);
            check({tag, "_last"},  {7'd0, ifa.out_last}, (i == 3) ? 8'd1 : 8'd0);
            check({tag, "_ovf"},   {6'd0, ifa.ovf}, (i == 3) ? {6'd0, eovf} : 8'd0);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    drive_a(1'b0, 2'b00, ~m_rest, 1'b0);
                    tick();
                    check({tag, "_gap_valid"}, {7'd0, ifa.out_valid}, 8'd0);
                    check({tag, "_gap_hold"},  {6'd0, ifa.outcode}, {6'd0, e1[i], e0[i]});
                end
            end
        end
        drive_a(1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive_a(1'b0, 2'b00, 2'b00, 1'b0);
        ifb.in_valid = 1'b0;
        ifb.incode   = 1'b0;
        ifb.mode     = 2'b00;
        ifb.abort    = 1'b0;
        tick();
        tick();
        check("rst_out",   {6'd0, ifa.outcode}, 8'd0);
        check("rst_valid", {7'd0, ifa.out_valid}, 8'd0);
        check("rst_last",  {7'd0, ifa.out_last}, 8'd0);
        check("rst_ovf",   {6'd0, ifa.ovf}, 8'd0);
        rst = 1'b0;
        tick();

        // NEG: 6 -> 10 (1010), 1 -> 15 (1111), no overflow
        send_word("neg_6_1", 2'b01, 2'b01, 4'b0110, 4'b0001, 4'b1010, 4'b1111, 2'b00, 0);
        // NEG: most negative value on lane0 overflows and passes through unchanged
        send_word("neg_8_0", 2'b01, 2'b01, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 2'b01, 0);
        // Back-to-back NEG words: INVERT state must not leak into the second word
        send_word("b2b_a", 2'b01, 2'b01, 4'b0110, 4'b1000, 4'b1010, 4'b1000, 2'b10, 0);
        send_word("b2b_b", 2'b01, 2'b01, 4'b0011, 4'b0101, 4'b1101, 4'b1011, 2'b00, 0);
        // PASS and ONES
        send_word("pass", 2'b00, 2'b00, 4'b0101, 4'b1100, 4'b0101, 4'b1100, 2'b00, 0);
        send_word("ones", 2'b10, 2'b10, 4'b0101, 4'b1100, 4'b1010, 4'b0011, 2'b00, 0);
        // Reserved code behaves as PASS, even for the most negative value
        send_word("rsvd", 2'b11, 2'b11, 4'b1000, 4'b0110, 4'b1000, 4'b0110, 2'b00, 0);
        // Gaps between bits leave the result unchanged
        send_word("gap1", 2'b01, 2'b01, 4'b0110, 4'b0001, 4'b1010, 4'b1111, 2'b00, 1);
        send_word("gap3", 2'b10, 2'b10, 4'b0101, 4'b0000, 4'b1010, 4'b1111, 2'b00, 3);
        // Mode changed mid-word is ignored
        send_word("modechg_neg", 2'b01, 2'b10, 4'b0110, 4'b0001, 4'b1010, 4'b1111, 2'b00, 0);
        send_word("modechg_pass", 2'b00, 2'b01, 4'b0110, 4'b1000, 4'b0110, 4'b1000, 2'b00, 0);

        // Abort after two bits of NEG 0110; the bit presented with abort is dropped
        drive_a(1'b1, 2'b00, 2'b01, 1'b0);
        tick();
        drive_a(1'b1, 2'b01, 2'b01, 1'b0);
        tick();
        drive_a(1'b1, 2'b11, 2'b01, 1'b1);
        tick();
        check("abort_valid", {7'd0, ifa.out_valid}, 8'd0);
        check("abort_last",  {7'd0, ifa.out_last}, 8'd0);
        check("abort_ovf",   {6'd0, ifa.ovf}, 8'd0);
        send_word("after_abort", 2'b01, 2'b01, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 2'b00, 0);

        // Same scenario with reset instead of abort
        drive_a(1'b1, 2'b00, 2'b01, 1'b0);
        tick();
        drive_a(1'b1, 2'b11, 2'b01, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out",   {6'd0, ifa.outcode}, 8'd0);
        check("midrst_valid", {7'd0, ifa.out_valid}, 8'd0);
        check("midrst_last",  {7'd0, ifa.out_last}, 8'd0);
        check("midrst_ovf",   {6'd0, ifa.ovf}, 8'd0);
        send_word("after_rst", 2'b01, 2'b01, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 2'b00, 0);

        // WIDTH=1: NEG stream 1,0,1 -> out 1,0,1, ovf 1,0,1, last on every output
        for (int i = 0; i < 3; i++) begin
            ifb.in_valid = 1'b1;
            ifb.incode   = (i == 1) ? 1'b0 : 1'b1;
            ifb.mode     = 2'b01;
            tick();
            $display("w1 bit%0d out=%b valid=%b last=%b ovf=%b", i,
                     ifb.outcode, ifb.out_valid, ifb.out_last, ifb.ovf);
            check("w1_out",   {7'd0, ifb.outcode}, (i == 1) ? 8'd0 : 8'd1);
            check("w1_ovf",   {7'd0, ifb.ovf},     (i == 1) ? 8'd0 : 8'd1);
            check("w1_last",  {7'd0, ifb.out_last}, 8'd1);
            check("w1_valid", {7'd0, ifb.out_valid}, 8'd1);
        end
        ifb.in_valid = 1'b0;
        tick();
        check("w1_idle_valid", {7'd0, ifb.out_valid}, 8'd0);
        check("w1_idle_ovf",   {7'd0, ifb.ovf}, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/twos_comp_serial.md
# twos_comp_serial

Parametrised, multi-lane, bit-serial two's-complement unit, LSB first, with explicit word framing and selectable mode. Each of CH lanes runs the classic copy-until-first-one-then-invert FSM. Lane state re-arms automatically at every WIDTH-bit word boundary. The block adds an input qualifier, a pass/negate/invert mode, per-word overflow detection and a mid-word abort. It sits between the serial deserialiser front end and the downstream serial accumulators.

## Interface
- WIDTH, 8: bits per word (≥1); bit index counter wraps at WIDTH-1.
- CH, 1: number of independent lanes sharing one bit clock and valid.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  current incode bits are accepted this cycle.
- incode  input  CH  one serial bit per lane, LSB of word first.
- mode  input  2  00 PASS, 01 NEG (two's complement), 10 ONES (bitwise invert), 11 reserved, decoded as PASS.
- abort  input  1  discard the current partial word; re-arm all lanes.
- outcode  output  CH  processed serial bit per lane.
- out_valid  output  1  outcode carries a valid bit.
- out_last  output  1  outcode is the MSB (index WIDTH-1) of a word.
- ovf  output  CH  per-lane overflow pulse, coincident with out_last.

## Operation
- Bit counter `idx` counts accepted bits: 0..WIDTH-1, then wraps to 0.
  - Held when in_valid=0.
  - Cleared by abort or rst.
- Mode capture:
  - On the accepted bit with idx=0, the live `mode` is applied to that bit and latched as `mode_q`.
  - Bits 1..WIDTH-1 use `mode_q`.
  - Mode changes mid-word are ignored.
- Per-lane state: COPY / INVERT. The state is forced to COPY on every accepted bit with idx=0, before that bit is evaluated.
  - NEG, COPY: out = in; if in=1, go to INVERT.
  - NEG, INVERT: out = ~in; stay in INVERT until the word ends.
  - PASS: out = in; state unused.
  - ONES: out = ~in; state unused.
- Overflow applies to NEG mode only. On the accepted bit with idx=WIDTH-1, ovf[i]=1 when lane i is still in COPY and in=1.
  - This means the input word was the most-negative value, 100…0.
  - The output word equals the input word in this case.
  - In PASS and ONES, ovf=0.
- WIDTH=1: every bit is both first and last.
  - NEG of 1 gives out 1 with ovf=1.
  - NEG of 0 gives out 0 with ovf=0.
- abort (synchronous):
  - Next cycle, idx=0, all lanes are in COPY and out_valid=0.
  - A bit presented together with abort is dropped (abort wins over in_valid).
- Reset values:
  - outcode=0, out_valid=0, out_last=0, ovf=0.
  - idx=0, all lanes in COPY, mode_q=PASS.
- in_valid=0:
  - out_valid, out_last and ovf are 0 the next cycle.
  - outcode holds its previous value.
  - No state changes.

## Timing
- All outputs are registered. Latency is 1 cycle from an accepted bit to its outcode/out_valid.
- Throughput is 1 bit per lane per cycle. Back-to-back words need no idle cycles.
- out_last and ovf are single-cycle pulses aligned with the MSB output bit.
- rst mid-word discards the partial word, exactly as abort does. rst has priority over abort and in_valid.

## Structure
- Package `twos_comp_pkg` holds:
  - mode constants MODE_PASS, MODE_NEG, MODE_ONES;
  - state encodings ST_COPY, ST_INVERT.
- Sub-module `twos_comp_lane`: one lane's state bit, output bit and ovf logic.
  - Inputs: first, last, mode and in bit.
  - Instantiated CH times in a generate loop.
- The top level owns idx, mode_q, the valid/last pipeline and abort/reset priority.

## Test plan
All cases use WIDTH=4, CH=2 unless noted; bit lists are LSB first.
- NEG, lane0 0110 (bits 0,1,1,0), lane1 0001 → lane0 out bits 0,1,0,1 (1010), lane1 out 1111. ovf=00; out_last on the 4th output.
- NEG, lane0 1000, lane1 0000 → lane0 out 1000 with ovf[0]=1 on the MSB; lane1 out 0000, ovf[1]=0.
- Back-to-back NEG words 0110 then 0011 on lane0, no gaps → 1010 then 1101. The INVERT state does not leak across the boundary.
- Mode sequence:
  - PASS word 0101 → 0101.
  - ONES word 0101 → 1010.
  - In-valid gaps of 1–3 cycles between bits leave results unchanged, with out_valid low during the gaps.
  - mode toggled at idx=2 has no effect on the current word.
- abort after 2 bits of NEG 0110, then a fresh word 0001 → 1111. Repeat with rst instead of abort → identical result, and all outputs are 0 the cycle after rst.
- WIDTH=1, CH=1, NEG stream 1,0,1 → out 1,0,1; ovf=1,0,1; out_last high on every valid output.
